decoder_scan_sequencer: RTL
===========================

// Module: decoder_scan_sequencer
// PURPOSE
//  Registered, parametrised N-to-2^N one-hot decoder with enable, extended with an autonomous
//  scan engine that walks the one-hot output across a channel range with programmable dwell.
//  Drives register-bank / lane write-enables and peripheral selects in the CPU datapath.
//  DIRECT mode replaces a bare combinational decoder where a registered, glitch-free select is needed.
// PARAMETERS
//  N        4  code width; output width OUTS = 2**N (localparam)
//  DWELL_W  8  width of dwell counter (cycles per channel minus one)
// PORTS
//  clk    in   1        clock, rising edge
//  rst_n  in   1        asynchronous, active-low reset
//  en     in   1        enabler; low forces o to zero and pauses the scan
//  mode   in   2        00 OFF, 01 DIRECT, 10 SCAN_ONCE, 11 SCAN_LOOP
//  code   in   N        DIRECT: channel to select; SCAN: start channel (sampled on start)
//  last   in   N        SCAN: final channel (sampled on start)
//  dwell  in   DWELL_W  SCAN: each channel held dwell+1 enabled cycles (sampled on start)
//  start  in   1        one-cycle pulse; begins a scan when idle and mode[1]=1
//  o      out  OUTS     registered one-hot (or all-zero) select
//  cur    out  N        index currently driven (valid while o != 0)
//  busy   out  1        high while a scan is active
//  done   out  1        one-cycle pulse when a SCAN_ONCE completes
// BEHAVIOUR
//  Reset: o=0, cur=0, busy=0, done=0, dwell count=0, FSM=IDLE; applies immediately, mid-scan included.
//  FSM IDLE: mode=01 -> o <= en ? 1<<code : 0 every cycle (latency 1 clk); mode=00 -> o <= 0.
//   start & mode[1] -> latch start_idx=code, last_idx=last, dwell_r=dwell; cur<=code, cnt<=0,
//   busy<=1, FSM=SCAN; o <= 1<<code on the same edge if en=1. start with mode[1]=0 is ignored.
//  FSM SCAN (counter advances only on cycles with en=1):
//   cnt<dwell_r -> cnt++. cnt==dwell_r -> cnt<=0 and:
//    cur!=last_idx -> cur <= cur+1 modulo 2**N (last<start wraps through OUTS-1 -> 0).
//    cur==last_idx & SCAN_ONCE -> o<=0, busy<=0, done<=1 for one cycle, FSM=IDLE.
//    cur==last_idx & SCAN_LOOP -> cur<=start_idx (no gap cycle, no done).
//   start==last: single-channel scan. en=0: o<=0, cur/cnt/FSM frozen; en=1 resumes same channel,
//   remaining dwell preserved. mode=00 while busy: abort next edge, o<=0, busy<=0, no done.
//   mode 10<->11 switch while busy: takes effect at the next end-of-range decision. mode=01 while
//   busy: ignored until scan ends. start while busy: ignored.
//  o is always one-hot or zero; o[cur] is the only set bit when non-zero.
// CONFIGURATION
//  DEC_SEQ_MASK_EN defined: extra input mask [OUTS-1:0]; masked channels skipped in SCAN at zero
//   cycle cost (next unmasked index on circular path toward last_idx; masked start channel -> first
//   unmasked after it). No unmasked channel in range: o stays 0, and next edge behaves as end of range
//   (SCAN_ONCE -> done; SCAN_LOOP -> busy held, o=0, re-evaluated every cycle). DIRECT: masked code -> o=0.
//   Mask sampled live each cycle, not latched on start.
//  Not defined: no mask port; all channels visited.
// STRUCTURE
//  Package dec_seq_pkg: mode_e enum (MODE_OFF, MODE_DIRECT, MODE_SCAN_ONCE, MODE_SCAN_LOOP),
//   state_e enum (ST_IDLE, ST_SCAN).
//  Sub-module: Decoder_with_enabler_N #(.N(N)) decodes the next index; its output feeds the o register.
//  Next-unmasked priority search kept local (generate block under DEC_SEQ_MASK_EN).
// TESTING
//  1 N=4, en=1, mode=01, code=0..15 one per clk -> o=1<<code one clk later; en=0 -> o=16'h0000 next clk.
//  2 mode=10, code=3, last=5, dwell=1, start -> o=0x0008 x2, 0x0010 x2, 0x0020 x2, then o=0, done pulse, busy=0.
//  3 mode=11, code=14, last=1, dwell=0 -> o cycles 0x4000,0x8000,0x0001,0x0002,0x4000... with no done.
//  4 Scan code=2,last=4,dwell=3; drop en for 5 clks mid-channel 3 -> o=0, cur=3 held; resume completes
//   remaining dwell on ch3 (total 4 enabled cycles).
//  5 rst_n low mid-scan -> o=0, busy=0, done=0 asynchronously; mode=00 mid-scan -> abort, no done.
//  6 DEC_SEQ_MASK_EN, mask=0x0014, code=2,last=5,dwell=0, mode=10 -> o=0x0008,0x0020, done; mask=0xFFFF -> done next clk, o=0.

Source files
------------

// File: rtl/decoder_scan_sequencer_pkg.sv
// rtl/decoder_scan_sequencer_pkg.sv - mode and FSM state types for the decoder scan sequencer
package dec_seq_pkg;

    typedef enum logic [1:0] {
        MODE_OFF       = 2'b00,
        MODE_DIRECT    = 2'b01,
        MODE_SCAN_ONCE = 2'b10,
        MODE_SCAN_LOOP = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

endpackage

// File: rtl/decoder_scan_sequencer_if.sv
// rtl/decoder_scan_sequencer_if.sv - control/select bundle of the scan sequencer (mask port with DEC_SEQ_MASK_EN)
interface decoder_scan_sequencer_if #(
    parameter int N       = 4,
    parameter int DWELL_W = 8
);
    logic                en;
    logic [1:0]          mode;
    logic [N-1:0]        code;
    logic [N-1:0]        last;
    logic [DWELL_W-1:0]  dwell;
    logic                start;
`ifdef DEC_SEQ_MASK_EN
    logic [(1<<N)-1:0]   mask;
`endif
    logic [(1<<N)-1:0]   o;
    logic [N-1:0]        cur;
    logic                busy;
    logic                done;

    modport master (
`ifdef DEC_SEQ_MASK_EN
        output mask,
`endif
        output en, mode, code, last, dwell, start,
        input  o, cur, busy, done
    );

    modport slave (
`ifdef DEC_SEQ_MASK_EN
        input  mask,
`endif
        input  en, mode, code, last, dwell, start,
        output o, cur, busy, done
    );
endinterface

// File: rtl/decoder_scan_sequencer_dec.sv
// rtl/decoder_scan_sequencer_dec.sv - N-to-2^N one-hot decoder with enable
module Decoder_with_enabler_N #(
    parameter int N = 4
) (
    input  logic              en,
    input  logic [N-1:0]      code,
    output logic [(1<<N)-1:0] o
);
    // one-hot select of code, all-zero when disabled
    always_comb begin
        o = '0;
        if (en) o[code] = 1'b1;
    end
endmodule

// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - registered one-hot decoder with scan engine (optional channel mask: DEC_SEQ_MASK_EN)
module decoder_scan_sequencer
    import dec_seq_pkg::*;
#(
    parameter int N       = 4,
    parameter int DWELL_W = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    decoder_scan_sequencer_if.slave bus
);
    localparam int OUTS = 1 << N;

    mode_e              mode;
    state_e             state_q, state_d;
    logic [N-1:0]       cur_q, cur_d;
    logic [N-1:0]       start_q, start_d;
    logic [N-1:0]       last_q, last_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic               loop_q, loop_d;
    logic               void_q, void_d;
    logic               done_q, done_d;
    logic [OUTS-1:0]    o_q, o_d;

    logic               loop_eff;
    logic [N-1:0]       from_a;
    logic [N-1:0]       first_idx, wrap_idx;
    logic               first_ok, wrap_ok;
    logic [N-1:0]       dec_idx;
    logic               dec_en;

    assign mode     = mode_e'(bus.mode);
    // Scan flavour follows the live mode while it is a scan mode; DIRECT during a scan keeps the last one.
    assign loop_eff = bus.mode[1] ? bus.mode[0] : loop_q;
    // Candidate channel: start code when launching, otherwise the channel after the current one.
    assign from_a   = (state_q == ST_IDLE) ? bus.code : cur_q + 1'b1;

`ifdef DEC_SEQ_MASK_EN
    logic [N-1:0] to_a;
    logic [N:0]   hit_a, hit_b;

    assign to_a = (state_q == ST_IDLE) ? bus.last : last_q;

    // Walks circularly from 'from' and stops at 'to'; returns {found, index}.
    function automatic logic [N:0] find_unmasked(input logic [N-1:0] from,
                                                 input logic [N-1:0] to,
                                                 input logic [OUTS-1:0] m);
        logic [N-1:0] idx;
        logic         hit;
        logic         stop;
        idx  = from;
        hit  = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < OUTS; i++) begin
            if (!hit && !stop) begin
                if (!m[idx])       hit  = 1'b1;
                else if (idx == to) stop = 1'b1;
                else               idx  = idx + 1'b1;
            end
        end
        return {hit, idx};
    endfunction

    // next unmasked channel toward the range end, and the loop restart channel
    always_comb begin
        hit_a = find_unmasked(from_a, to_a, bus.mask);
        hit_b = find_unmasked(start_q, last_q, bus.mask);
    end

    assign first_ok  = hit_a[N];
    assign first_idx = hit_a[N-1:0];
    assign wrap_ok   = hit_b[N];
    assign wrap_idx  = hit_b[N-1:0];
`else
    assign first_ok  = 1'b1;
    assign first_idx = from_a;
    assign wrap_ok   = 1'b1;
    assign wrap_idx  = start_q;
`endif

    // state register: FSM, scan context and the registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            start_q <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            loop_q  <= 1'b0;
            void_q  <= 1'b0;
            done_q  <= 1'b0;
            o_q     <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            start_q <= start_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            loop_q  <= loop_d;
            void_q  <= void_d;
            done_q  <= done_d;
            o_q     <= o_d;
        end
    end

    // next-state: launch, dwell counting, channel advance and end-of-range handling
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        start_d = start_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        loop_d  = loop_q;
        void_d  = void_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && bus.mode[1]) begin
                    start_d = bus.code;
                    last_d  = bus.last;
                    dwell_d = bus.dwell;
                    loop_d  = bus.mode[0];
                    cnt_d   = '0;
                    cur_d   = first_idx;
                    void_d  = ~first_ok;
                    state_d = ST_SCAN;
                end else if (mode == MODE_DIRECT) begin
                    cur_d = bus.code;
                end
            end
            ST_SCAN: begin
                if (bus.mode[1]) loop_d = bus.mode[0];
                if (mode == MODE_OFF) begin
                    state_d = ST_IDLE;
                end else if (bus.en) begin
                    if (!void_q && cnt_q != dwell_q) begin
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = '0;
                        if (!void_q && cur_q != last_q && first_ok) begin
                            cur_d = first_idx;
                        end else if (!loop_eff) begin
                            state_d = ST_IDLE;
                        end else begin
                            cur_d  = wrap_idx;
                            void_d = ~wrap_ok;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // outputs: decoder drive for the next select, done on a non-aborted scan exit
    always_comb begin
        dec_idx = cur_d;
        dec_en  = 1'b0;
        done_d  = 1'b0;
        if (state_d == ST_SCAN)
            dec_en = bus.en & ~void_d;
        else if (state_q == ST_IDLE && mode == MODE_DIRECT)
            dec_en = bus.en;
`ifdef DEC_SEQ_MASK_EN
        if (bus.mask[dec_idx]) dec_en = 1'b0;
`endif
        if (state_q == ST_SCAN && state_d == ST_IDLE && mode != MODE_OFF)
            done_d = 1'b1;
    end

    Decoder_with_enabler_N #(.N(N)) u_dec (
        .en   (dec_en),
        .code (dec_idx),
        .o    (o_d)
    );

    assign bus.o    = o_q;
    assign bus.cur  = cur_q;
    assign bus.busy = (state_q == ST_SCAN);
    assign bus.done = done_q;
endmodule
